// File: rtl/sync_down_counter.sv
// Loadable down counter / programmable timer: counts a loaded value to zero,
// pulses TC for one cycle on arrival, and either stops (one-shot) or reloads (periodic).
module sync_down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             En,
   input  logic             Mode,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             Busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_next;
   logic [WIDTH-1:0] q, q_next;
   logic [WIDTH-1:0] reload, reload_next;
   logic             tc, tc_next;
   logic             busy;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= IDLE;
         q      <= '0;
         reload <= '0;
         tc     <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_next;
         q      <= q_next;
         reload <= reload_next;
         tc     <= tc_next;
         busy   <= (state_next == RUN);
      end
   end

   // Load beats everything; IDLE and DONE simply hold until the next load.
   always_comb begin
      state_next  = state;
      q_next      = q;
      reload_next = reload;
      tc_next     = 1'b0;
      if (Load) begin
         q_next      = D;
         reload_next = D;
         state_next  = (D != '0) ? RUN : IDLE;
      end else if (state == RUN && En) begin
         if (q > ONE) begin
            q_next = q - ONE;
         end else if (q == ONE) begin
            q_next  = '0;
            tc_next = 1'b1;
            if (!Mode) state_next = DONE;
         end else if (Mode) begin
            q_next = reload;
         end else begin
            state_next = DONE;
         end
      end
   end

   assign Q         = q;
   assign TC        = tc;
   assign Busy      = busy;
   assign dbg_state = state;

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter (WIDTH=4): directed vector table,
// hand-written corner sequences, and randomized traffic against a reference model.
module tb_sync_down_counter;

   localparam int W = 4;

   logic         CLK, Reset_n, Load, En, Mode;
   logic [W-1:0] D;
   logic [W-1:0] Q;
   logic         TC, Busy;
   logic [1:0]   dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   sync_down_counter #(.WIDTH(W)) dut (
      .CLK(CLK), .Reset_n(Reset_n), .Load(Load), .D(D), .En(En), .Mode(Mode),
      .Q(Q), .TC(TC), .Busy(Busy), .dbg_state(dbg_state)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic l, input logic [W-1:0] d, input logic e, input logic m);
      @(negedge CLK);
      Load = l; D = d; En = e; Mode = m;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_out(input string tag, input int q, input int tc, input int busy);
      check({tag, ".Q"}, int'(Q), q);
      check({tag, ".TC"}, int'(TC), tc);
      check({tag, ".Busy"}, int'(Busy), busy);
   endtask

   // Reference model: only "is it still counting" matters externally,
   // since IDLE and DONE look identical on the outputs.
   int m_q, m_rel, m_tc;
   bit m_run;

   task automatic model_step(input logic l, input int d, input logic e, input logic m);
      m_tc = 0;
      if (l) begin
         m_q = d; m_rel = d; m_run = (d != 0);
      end else if (m_run && e) begin
         if (m_q >= 2) m_q = m_q - 1;
         else if (m_q == 1) begin
            m_q = 0; m_tc = 1; m_run = m;
         end else if (m) m_q = m_rel;
         else m_run = 0;
      end
   endtask

   typedef struct {
      logic         load;
      logic [W-1:0] d;
      logic         en;
      logic         mode;
      logic [W-1:0] q;
      logic         tc;
      logic         busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic l, input int d, input logic e, input logic m,
                               input int q, input logic tc, input logic busy);
      vec_t v;
      v.load = l; v.d = W'(d); v.en = e; v.mode = m; v.q = W'(q); v.tc = tc; v.busy = busy;
      return v;
   endfunction

   initial begin
      logic prev_tc;
      int   tc_seen;

      Reset_n = 1'b0; Load = 1'b0; D = '0; En = 1'b0; Mode = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_out("reset", 0, 0, 0);
      check("reset.state", int'(dbg_state), 0);
      @(negedge CLK);
      Reset_n = 1'b1;

      // Idle with En: nothing happens.
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));
      // One-shot from 5.
      vecs.push_back(mk(1, 5, 0, 0, 5, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 4, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));
      // Auto-reload from 3, load cycle does not decrement.
      vecs.push_back(mk(1, 3, 1, 1, 3, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 3, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 1, 3, 0, 1));
      // Enable gating, then load over a running count.
      vecs.push_back(mk(1, 4, 0, 1, 4, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 3, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 3, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 3, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1));
      vecs.push_back(mk(1, 9, 1, 1, 9, 0, 1));
      // Load of zero.
      vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));
      // Load on the 1->0 edge suppresses TC.
      vecs.push_back(mk(1, 2, 0, 0, 2, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
      vecs.push_back(mk(1, 6, 1, 0, 6, 0, 1));
      // Mode dropped before the reload edge -> finished.
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));
      // En low at zero does not stretch TC; reload still follows.
      vecs.push_back(mk(1, 1, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));

      foreach (vecs[i]) begin
         apply(vecs[i].load, vecs[i].d, vecs[i].en, vecs[i].mode);
         check_out($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].tc), int'(vecs[i].busy));
      end

      // One-shot hold: ten more enabled cycles after finishing.
      apply(1, 5, 0, 0);
      repeat (5) apply(0, 0, 1, 0);
      check_out("oneshot_end", 0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         apply(0, 0, 1, i[0]);
         check_out("oneshot_hold", 0, 0, 0);
      end

      // Full-scale load: TC after exactly 15 enabled cycles, 15 never reappears.
      apply(1, 15, 0, 0);
      tc_seen = 0;
      for (int i = 1; i <= 15; i++) begin
         apply(0, 0, 1, 0);
         check("max.Q", int'(Q), 15 - i);
         check("max.TC", int'(TC), (i == 15) ? 1 : 0);
      end
      for (int i = 0; i < 4; i++) begin
         apply(0, 0, 1, 0);
         check("max.hold_Q", int'(Q), 0);
      end

      // Asynchronous reset between clock edges.
      apply(1, 12, 0, 0);
      repeat (5) apply(0, 0, 1, 0);
      check("async.pre_Q", int'(Q), 7);
      #2;
      Reset_n = 1'b0;
      #1;
      check_out("async.now", 0, 0, 0);
      @(negedge CLK);
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 1, 1);
         check_out("async.after", 0, 0, 0);
      end

      // Randomized traffic against the model (DUT is IDLE with reload 0 here).
      m_q = 0; m_rel = 0; m_run = 0; m_tc = 0;
      prev_tc = 1'b0;
      for (int i = 0; i < 600; i++) begin
         logic l, e, m;
         int   d;
         l = ($urandom_range(0, 9) == 0);
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
         e = ($urandom_range(0, 3) != 0);
         m = ($urandom_range(0, 4) != 0);
         apply(l, W'(d), e, m);
         model_step(l, d, e, m);
         check_out("rand", m_q, m_tc, m_run ? 1 : 0);
         check("rand.tc_pair", int'(prev_tc & TC), 0);
         prev_tc = TC;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
